// File: rtl/box_scan_ctrl.sv
// Point-in-box scan sequencer: walks the box table one entry per cycle against a
// latched probe and publishes a hit bitmask, any-hit flag and lowest hit index.
module box_scan_ctrl #(
  parameter  int N_BOX = 8,
  localparam int IDX_W = $clog2(N_BOX)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [9:0]       probe_x,
  input  logic [9:0]       probe_y,
  output logic [IDX_W-1:0] box_idx,
  input  logic [9:0]       box_cx,
  input  logic [9:0]       box_cy,
  input  logic [9:0]       box_w,
  input  logic [9:0]       box_h,
  input  logic             box_en,
  output logic             busy,
  output logic             done,
  output logic [N_BOX-1:0] hit_mask,
  output logic             any_hit,
  output logic [IDX_W-1:0] first_hit
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic [9:0]         px, py;
  logic [N_BOX-1:0]   scratch, pub;
  logic [IDX_W-1:0]   first_nxt;
  logic               load, publish, last, hit;

  // 11-bit compare so center+half-size never wraps at the 1023 edge
  logic [10:0] px_w, cx_w, py_h, cy_h;
  assign px_w = {1'b0, px} + {1'b0, box_w};
  assign cx_w = {1'b0, box_cx} + {1'b0, box_w};
  assign py_h = {1'b0, py} + {1'b0, box_h};
  assign cy_h = {1'b0, box_cy} + {1'b0, box_h};
  assign hit  = box_en && (px_w >= {1'b0, box_cx}) && ({1'b0, px} <= cx_w)
                       && (py_h >= {1'b0, box_cy}) && ({1'b0, py} <= cy_h);

  assign last = (box_idx == IDX_W'(N_BOX - 1));
  assign pub  = scratch | (N_BOX'(hit) << box_idx);

  always_comb begin
    first_nxt = '0;
    for (int i = N_BOX - 1; i >= 0; i--)
      if (pub[i]) first_nxt = IDX_W'(i);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (abort) state_nxt = IDLE;
        else if (last) begin
          publish   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A start held through DONE restarts directly, giving an N_BOX+1 cycle period
        if (abort) state_nxt = IDLE;
        else if (start) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px        <= '0;
      py        <= '0;
      scratch   <= '0;
      box_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_mask  <= '0;
      any_hit   <= 1'b0;
      first_hit <= '0;
    end else begin
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      box_idx <= (state == SCAN && state_nxt == SCAN) ? box_idx + 1'b1 : '0;
      if (load) begin
        px      <= probe_x;
        py      <= probe_y;
        scratch <= '0;
      end else if (state == SCAN) begin
        scratch <= pub;
      end
      if (publish) begin
        hit_mask  <= pub;
        any_hit   <= |pub;
        first_hit <= first_nxt;
      end
    end
  end

endmodule

// File: tb/tb_box_scan_ctrl.sv
// Randomized + directed bench for box_scan_ctrl: stimulus pushes reference results
// into a queue, a monitor pops and compares on every done pulse.
module tb_box_scan_ctrl;
  localparam int N_BOX = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [N_BOX-1:0] m;
    logic             a;
    logic [IDX_W-1:0] f;
  } res_t;

  logic             Clk, Reset_n, start, abort, clk_en;
  logic [9:0]       probe_x, probe_y, box_cx, box_cy, box_w, box_h;
  logic             box_en, busy, done, any_hit;
  logic [IDX_W-1:0] box_idx, first_hit;
  logic [N_BOX-1:0] hit_mask;

  logic [9:0] tcx [N_BOX];
  logic [9:0] tcy [N_BOX];
  logic [9:0] tw  [N_BOX];
  logic [9:0] th  [N_BOX];
  logic       ten [N_BOX];

  res_t q[$];
  int   n_cmp = 0, n_bad = 0;

  box_scan_ctrl #(.N_BOX(N_BOX)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
    .probe_x(probe_x), .probe_y(probe_y), .box_idx(box_idx),
    .box_cx(box_cx), .box_cy(box_cy), .box_w(box_w), .box_h(box_h), .box_en(box_en),
    .busy(busy), .done(done), .hit_mask(hit_mask), .any_hit(any_hit), .first_hit(first_hit)
  );

  // the table itself, read through the index port
  assign box_cx = tcx[box_idx];
  assign box_cy = tcy[box_idx];
  assign box_w  = tw[box_idx];
  assign box_h  = th[box_idx];
  assign box_en = ten[box_idx];

  initial begin
    Clk = 1'b0;
    wait (clk_en);
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // containment straight from the geometric rule, in unbounded int arithmetic
  function automatic res_t ref_scan(input int x, input int y);
    res_t r;
    r = '0;
    for (int i = 0; i < N_BOX; i++) begin
      int cx = int'(tcx[i]), cy = int'(tcy[i]), w = int'(tw[i]), h = int'(th[i]);
      if (ten[i] && x >= cx - w && x <= cx + w && y >= cy - h && y <= cy + h) r.m[i] = 1'b1;
    end
    r.a = (r.m != '0);
    for (int i = N_BOX - 1; i >= 0; i--) if (r.m[i]) r.f = IDX_W'(i);
    return r;
  endfunction

  always @(posedge Clk) begin
    #1;
    if (Reset_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
      else begin
        res_t e;
        e = q.pop_front();
        chk("hit_mask", 32'(hit_mask), 32'(e.m));
        chk("any_hit", 32'(any_hit), 32'(e.a));
        chk("first_hit", 32'(first_hit), 32'(e.f));
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < N_BOX; i++) begin
      tcx[i] = 10'd0; tcy[i] = 10'd0; tw[i] = 10'd0; th[i] = 10'd0; ten[i] = 1'b0;
    end
  endtask

  task automatic set_box(input int i, input int cx, input int cy, input int w, input int h, input logic en);
    tcx[i] = 10'(cx); tcy[i] = 10'(cy); tw[i] = 10'(w); th[i] = 10'(h); ten[i] = en;
  endtask

  // called at a negedge; checks busy/done cycle by cycle with the probe scrambled mid-scan
  task automatic do_scan(input int x, input int y);
    start = 1'b1; probe_x = 10'(x); probe_y = 10'(y);
    q.push_back(ref_scan(x, y));
    for (int i = 0; i <= N_BOX + 1; i++) begin
      @(negedge Clk);
      start = 1'b0;
      probe_x = 10'($urandom_range(0, 1023));
      probe_y = 10'($urandom_range(0, 1023));
      chk($sformatf("busy@%0d", i), 32'(busy), 32'(i <= N_BOX));
      chk($sformatf("done@%0d", i), 32'(done), 32'(i == N_BOX));
    end
  endtask

  task automatic chk_res(input string nm, input int m, input int a, input int f);
    chk({nm, ".mask"}, 32'(hit_mask), 32'(m));
    chk({nm, ".any"}, 32'(any_hit), 32'(a));
    chk({nm, ".first"}, 32'(first_hit), 32'(f));
  endtask

  initial begin
    clk_en = 1'b0; Reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    probe_x = '0; probe_y = '0;
    clear_table();
    #20;
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.idx", 32'(box_idx), 32'(0));
    chk_res("rst", 0, 0, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // single hit on the box edge, then boundary and enable cases
    set_box(3, 105, 100, 5, 5, 1'b1);
    do_scan(100, 100); chk_res("edge_hit", 8'h08, 1, 3);
    do_scan(99, 100);  chk_res("edge_miss", 0, 0, 0);
    do_scan(110, 105); chk_res("corner_hit", 8'h08, 1, 3);
    ten[3] = 1'b0;
    do_scan(100, 100); chk_res("disabled", 0, 0, 0);

    clear_table();
    set_box(0, 1020, 0, 10, 0, 1'b1);
    do_scan(1023, 0); chk_res("no_wrap", 8'h01, 1, 0);

    clear_table();
    set_box(2, 200, 200, 1, 1, 1'b1);
    set_box(5, 195, 205, 10, 10, 1'b1);
    set_box(6, 300, 300, 5, 5, 1'b1);
    do_scan(200, 200); chk_res("multi", 8'h24, 1, 2);

    // start held high: accepted at edges 0, 9, 18
    start = 1'b1; probe_x = 10'd200; probe_y = 10'd200;
    repeat (3) q.push_back(ref_scan(200, 200));
    for (int i = 0; i < 3 * (N_BOX + 1); i++) begin
      @(negedge Clk);
      if (i == 3 * (N_BOX + 1) - 1) start = 1'b0;
      chk($sformatf("spam.busy@%0d", i), 32'(busy), 32'(1));
      chk($sformatf("spam.done@%0d", i), 32'(done), 32'(i % (N_BOX + 1) == N_BOX));
    end
    @(negedge Clk);
    chk("spam.idle", 32'(busy), 32'(0));
    chk_res("spam", 8'h24, 1, 2);

    // abort at box_idx 4: nothing published, back to IDLE next edge
    tcx[6] = 10'd200; tcy[6] = 10'd200;
    start = 1'b1; probe_x = 10'd200; probe_y = 10'd200;
    @(negedge Clk); start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("abort.idx", 32'(box_idx), 32'(4));
    abort = 1'b1; start = 1'b1;
    @(negedge Clk);
    abort = 1'b0; start = 1'b0;
    chk("abort.busy", 32'(busy), 32'(0));
    chk("abort.done", 32'(done), 32'(0));
    chk("abort.idx0", 32'(box_idx), 32'(0));
    chk_res("abort", 8'h24, 1, 2);
    abort = 1'b1;
    repeat (3) @(negedge Clk);
    abort = 1'b0;
    chk("abort_idle.busy", 32'(busy), 32'(0));
    do_scan(200, 200); chk_res("after_abort", 8'h64, 1, 2);

    // randomized tables clustered around the probe
    for (int t = 0; t < 25; t++) begin
      int x = $urandom_range(30, 990), y = $urandom_range(30, 990);
      for (int i = 0; i < N_BOX; i++)
        set_box(i, x + $urandom_range(0, 40) - 20, y + $urandom_range(0, 40) - 20,
                $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0));
      do_scan(x, y);
    end

    // reset mid-scan after 3 entries clears immediately
    clear_table();
    set_box(1, 50, 50, 3, 3, 1'b1);
    do_scan(50, 50); chk_res("pre_rst", 8'h02, 1, 1);
    start = 1'b1;
    @(negedge Clk); start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'(0));
    chk("midrst.done", 32'(done), 32'(0));
    chk("midrst.idx", 32'(box_idx), 32'(0));
    chk_res("midrst", 0, 0, 0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (N_BOX + 3) @(negedge Clk);
    chk("midrst.stay_idle", 32'(busy), 32'(0));
    do_scan(51, 48); chk_res("post_rst", 8'h02, 1, 1);

    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
